// File: rtl/sa_pkg.sv
// Shared widths, opcode encodings, instruction field indices and per-opcode hold
// counts for the systolic-array instruction sequencer and its benches.
package sa_pkg;

    localparam int OPCODE_BITS = 4;
    localparam int ADDR_BITS   = 8;
    localparam int DIN_BITS    = 128;
    localparam int DOUT_BITS   = 320;
    localparam int INST_BITS   = OPCODE_BITS + 2 * ADDR_BITS;
    localparam int CNT_BITS    = 6;

    localparam int OPCODE_FROM = INST_BITS - 1;
    localparam int OPCODE_TO   = 2 * ADDR_BITS;
    localparam int ADDRA_FROM  = 2 * ADDR_BITS - 1;
    localparam int ADDRA_TO    = ADDR_BITS;
    localparam int ADDRB_FROM  = ADDR_BITS - 1;
    localparam int ADDRB_TO    = 0;

    localparam logic [OPCODE_BITS-1:0] OP_IDLE         = 4'd0;
    localparam logic [OPCODE_BITS-1:0] OP_WRITE_DATA   = 4'd1;
    localparam logic [OPCODE_BITS-1:0] OP_WRITE_WEIGHT = 4'd2;
    localparam logic [OPCODE_BITS-1:0] OP_LOAD_DATA    = 4'd3;
    localparam logic [OPCODE_BITS-1:0] OP_LOAD_WEIGHT  = 4'd4;
    localparam logic [OPCODE_BITS-1:0] OP_MAT_MUL      = 4'd5;
    localparam logic [OPCODE_BITS-1:0] OP_MAT_MUL_ACC  = 4'd6;
    localparam logic [OPCODE_BITS-1:0] OP_WRITE_RESULT = 4'd7;
    localparam logic [OPCODE_BITS-1:0] OP_READ_UB      = 4'd8;

    localparam logic [CNT_BITS-1:0] IDLE_CYCLE         = 6'd1;
    localparam logic [CNT_BITS-1:0] WRITE_DATA_CYCLE   = 6'd1;
    localparam logic [CNT_BITS-1:0] WRITE_WEIGHT_CYCLE = 6'd1;
    localparam logic [CNT_BITS-1:0] LOAD_DATA_CYCLE    = 6'd1;
    localparam logic [CNT_BITS-1:0] LOAD_WEIGHT_CYCLE  = 6'd16;
    localparam logic [CNT_BITS-1:0] MAT_MUL_CYCLE      = 6'd32;
    localparam logic [CNT_BITS-1:0] MAT_MUL_ACC_CYCLE  = 6'd32;
    localparam logic [CNT_BITS-1:0] WRITE_RESULT_CYCLE = 6'd1;
    localparam logic [CNT_BITS-1:0] READ_UB_CYCLE      = 6'd2;

    localparam logic [INST_BITS-1:0] IDLE_INST = '0;

    typedef enum logic {S_IDLE, S_HOLD} state_t;

    function automatic logic opcode_legal(input logic [OPCODE_BITS-1:0] opcode);
        return opcode <= OP_READ_UB;
    endfunction

    // Illegal opcodes occupy the bus (as IDLE_INST) for a single cycle.
    function automatic logic [CNT_BITS-1:0] hold_cycles(input logic [OPCODE_BITS-1:0] opcode);
        logic [CNT_BITS-1:0] h;
        case (opcode)
            OP_IDLE:         h = IDLE_CYCLE;
            OP_WRITE_DATA:   h = WRITE_DATA_CYCLE;
            OP_WRITE_WEIGHT: h = WRITE_WEIGHT_CYCLE;
            OP_LOAD_DATA:    h = LOAD_DATA_CYCLE;
            OP_LOAD_WEIGHT:  h = LOAD_WEIGHT_CYCLE;
            OP_MAT_MUL:      h = MAT_MUL_CYCLE;
            OP_MAT_MUL_ACC:  h = MAT_MUL_ACC_CYCLE;
            OP_WRITE_RESULT: h = WRITE_RESULT_CYCLE;
            OP_READ_UB:      h = READ_UB_CYCLE;
            default:         h = IDLE_CYCLE;
        endcase
        return h;
    endfunction

endpackage

// File: rtl/sa_rsp_reg.sv
// One-entry READ_UB response register; captures on cap_vld, 1-cycle latency to rsp_vld.
// Holds until rsp_rdy; a capture on the same edge as a pop wins and keeps rsp_vld high.
module sa_rsp_reg
    import sa_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 cap_vld,
    input  logic [DOUT_BITS-1:0] cap_dat,
    input  logic                 rsp_rdy,
    output logic                 rsp_vld,
    output logic [DOUT_BITS-1:0] rsp_dat
);

    logic                 valid_q, valid_d;
    logic [DOUT_BITS-1:0] data_q, data_d;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (cap_vld) begin
            valid_d = 1'b1;
            data_d  = cap_dat;
        end else if (valid_q && rsp_rdy) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign rsp_vld = valid_q;
    assign rsp_dat = data_q;

endmodule

// File: rtl/sa_instruction_sequencer.sv
// Issues host commands onto the systolic-array instruction/din bus for each opcode's hold
// count, then one IDLE cycle; cmd_ready is low while holding or while a READ_UB would overrun.
module sa_instruction_sequencer
    import sa_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [OPCODE_BITS-1:0] cmd_opcode,
    input  logic [ADDR_BITS-1:0]   cmd_addra,
    input  logic [ADDR_BITS-1:0]   cmd_addrb,
    input  logic [DIN_BITS-1:0]    cmd_din,
    output logic [INST_BITS-1:0]   instruction,
    output logic [DIN_BITS-1:0]    din,
    input  logic [DOUT_BITS-1:0]   dout,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [DOUT_BITS-1:0]   rsp_data,
    output logic                   busy,
    output logic                   err_opcode
);

    state_t                state_q, state_d;
    logic [INST_BITS-1:0]  inst_q, inst_d;
    logic [DIN_BITS-1:0]   din_q, din_d;
    logic [CNT_BITS-1:0]   cnt_q, cnt_d;
    logic                  rd_q, rd_d;
    logic                  err_q, err_d;
    logic                  cmd_accept;
    logic                  capture;

    // A READ_UB may only start if the response slot is free or drains on this edge.
    assign cmd_ready  = (state_q == S_IDLE) &&
                        !((cmd_opcode == OP_READ_UB) && rsp_valid && !rsp_ready);
    assign cmd_accept = cmd_valid && cmd_ready;

    always_comb begin
        state_d = state_q;
        inst_d  = inst_q;
        din_d   = din_q;
        cnt_d   = cnt_q;
        rd_d    = rd_q;
        err_d   = 1'b0;
        capture = 1'b0;
        if (state_q == S_IDLE) begin
            if (cmd_accept) begin
                state_d = S_HOLD;
                cnt_d   = hold_cycles(cmd_opcode);
                rd_d    = (cmd_opcode == OP_READ_UB);
                if (opcode_legal(cmd_opcode)) begin
                    inst_d = {cmd_opcode, cmd_addra, cmd_addrb};
                    din_d  = cmd_din;
                end else begin
                    inst_d = IDLE_INST;
                    err_d  = 1'b1;
                end
            end
        end else begin
            cnt_d = cnt_q - 6'd1;
            if (cnt_q <= 6'd1) begin
                state_d = S_IDLE;
                inst_d  = IDLE_INST;
                cnt_d   = '0;
                rd_d    = 1'b0;
                capture = rd_q;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            inst_q  <= IDLE_INST;
            din_q   <= '0;
            cnt_q   <= '0;
            rd_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            inst_q  <= inst_d;
            din_q   <= din_d;
            cnt_q   <= cnt_d;
            rd_q    <= rd_d;
            err_q   <= err_d;
        end
    end

    sa_rsp_reg u_rsp_reg (
        .clk     (clk),
        .reset_n (reset_n),
        .cap_vld (capture),
        .cap_dat (dout),
        .rsp_rdy (rsp_ready),
        .rsp_vld (rsp_valid),
        .rsp_dat (rsp_data)
    );

    assign instruction = inst_q;
    assign din         = din_q;
    assign busy        = (state_q == S_HOLD);
    assign err_opcode  = err_q;

endmodule

// File: tb/tb_sa_instruction_sequencer.sv
// Bench for sa_instruction_sequencer: directed vector table, hand-written corner
// sequences, then randomized traffic against a cycle-count reference model.
module tb_sa_instruction_sequencer;
    import sa_pkg::*;

    logic                   clk;
    logic                   reset_n;
    logic                   cmd_valid;
    logic                   cmd_ready;
    logic [OPCODE_BITS-1:0] cmd_opcode;
    logic [ADDR_BITS-1:0]   cmd_addra;
    logic [ADDR_BITS-1:0]   cmd_addrb;
    logic [DIN_BITS-1:0]    cmd_din;
    logic [INST_BITS-1:0]   instruction;
    logic [DIN_BITS-1:0]    din;
    logic [DOUT_BITS-1:0]   dout;
    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [DOUT_BITS-1:0]   rsp_data;
    logic                   busy;
    logic                   err_opcode;

    int n_tests = 0;
    int n_fail  = 0;

    sa_instruction_sequencer dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_opcode  (cmd_opcode),
        .cmd_addra   (cmd_addra),
        .cmd_addrb   (cmd_addrb),
        .cmd_din     (cmd_din),
        .instruction (instruction),
        .din         (din),
        .dout        (dout),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_data    (rsp_data),
        .busy        (busy),
        .err_opcode  (err_opcode)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]   op;
        logic [7:0]   a;
        logic [7:0]   b;
        logic [127:0] d;
        logic [19:0]  inst;
        logic         err;
        int           hold;
    } vec_t;

    vec_t vecs[11];

    // Hold lengths straight from the opcode table; anything above 8 is one cycle.
    int hold_tab[16] = '{1, 1, 1, 1, 16, 32, 32, 1, 2, 1, 1, 1, 1, 1, 1, 1};

    task automatic chk(input string name, input logic [319:0] act, input logic [319:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [319:0] rnd320();
        logic [319:0] r;
        for (int i = 0; i < 10; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic do_reset();
        reset_n   = 1'b0;
        cmd_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    // Entered and left at negedge+1 with the DUT idle, so consecutive calls issue back-to-back.
    task automatic apply_vec(input vec_t v);
        cmd_opcode = v.op;
        cmd_addra  = v.a;
        cmd_addrb  = v.b;
        cmd_din    = v.d;
        cmd_valid  = 1'b1;
        #1 chk("vec_ready_at_offer", cmd_ready, 1);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        for (int k = 0; k < v.hold; k++) begin
            @(negedge clk);
            #1;
            chk("vec_inst_hold", instruction, v.inst);
            chk("vec_busy_hold", busy, 1);
            chk("vec_ready_hold", cmd_ready, 0);
            chk("vec_err", err_opcode, (k == 0) ? v.err : 1'b0);
            if (!v.err) chk("vec_din_hold", din, v.d);
        end
        @(negedge clk);
        #1;
        chk("vec_inst_after", instruction, 0);
        chk("vec_busy_after", busy, 0);
        chk("vec_err_after", err_opcode, 0);
    endtask

    // Reference model state
    int           m_rem;
    logic         m_read;
    logic [19:0]  m_inst;
    logic [127:0] m_din;
    logic         m_rv;
    logic [319:0] m_rd;
    logic         m_err;

    initial begin
        logic [319:0] pat;
        logic         exp_ready;
        logic         legal;

        reset_n    = 1'b0;
        cmd_valid  = 1'b0;
        cmd_opcode = '0;
        cmd_addra  = '0;
        cmd_addrb  = '0;
        cmd_din    = '0;
        dout       = '0;
        rsp_ready  = 1'b1;

        vecs[0]  = '{4'd1,  8'h05, 8'h00, 128'h0102030405060708090a0b0c0d0e0f10, 20'h10500, 1'b0, 1};
        vecs[1]  = '{4'd7,  8'h01, 8'h02, 128'h11, 20'h70102, 1'b0, 1};
        vecs[2]  = '{4'd5,  8'h03, 8'h03, 128'h22, 20'h50303, 1'b0, 32};
        vecs[3]  = '{4'd8,  8'h00, 8'h07, 128'h33, 20'h80007, 1'b0, 2};
        vecs[4]  = '{4'd12, 8'hff, 8'hff, 128'h44, 20'h00000, 1'b1, 1};
        vecs[5]  = '{4'd4,  8'h12, 8'h34, 128'h55, 20'h41234, 1'b0, 16};
        vecs[6]  = '{4'd2,  8'h10, 8'h20, 128'h66, 20'h21020, 1'b0, 1};
        vecs[7]  = '{4'd3,  8'haa, 8'h55, 128'h77, 20'h3aa55, 1'b0, 1};
        vecs[8]  = '{4'd0,  8'h09, 8'h09, 128'h88, 20'h00909, 1'b0, 1};
        vecs[9]  = '{4'd15, 8'h01, 8'h01, 128'h99, 20'h00000, 1'b1, 1};
        vecs[10] = '{4'd6,  8'h01, 8'h01, 128'haa, 20'h60101, 1'b0, 32};

        repeat (3) @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1;
            chk("idle_inst", instruction, 0);
            chk("idle_ready", cmd_ready, 1);
            chk("idle_busy", busy, 0);
        end
        chk("reset_din", din, 0);
        chk("reset_rsp_valid", rsp_valid, 0);
        chk("reset_rsp_data", rsp_data, 0);
        chk("reset_err", err_opcode, 0);

        foreach (vecs[i]) apply_vec(vecs[i]);

        // READ_UB capture with the consumer stalled
        rsp_ready = 1'b0;
        pat = {10{32'hc0de_0000 | 32'(10)}} ^ {40{8'h5a}};
        dout = pat;
        cmd_opcode = OP_READ_UB;
        cmd_addra  = 8'h00;
        cmd_addrb  = 8'h07;
        cmd_valid  = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            #1;
            chk("rd_inst", instruction, 20'h80007);
            chk("rd_valid_low", rsp_valid, 0);
        end
        @(negedge clk);
        #1;
        chk("rd_valid_high", rsp_valid, 1);
        chk("rd_data", rsp_data, pat);
        chk("rd_inst_idle", instruction, 0);
        dout = ~pat;
        cmd_valid = 1'b1;
        #1 chk("rd_second_stalled", cmd_ready, 0);
        @(negedge clk);
        #1;
        chk("rd_second_not_taken", busy, 0);
        cmd_opcode = OP_WRITE_DATA;
        cmd_addra  = 8'haa;
        cmd_addrb  = 8'hbb;
        #1 chk("wd_while_rsp_pending", cmd_ready, 1);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        @(negedge clk);
        #1;
        chk("wd_inst", instruction, 20'h1aabb);
        chk("rd_still_valid", rsp_valid, 1);
        chk("rd_data_held", rsp_data, pat);
        @(negedge clk);
        #1;

        // Reset in the middle of LOAD_WEIGHT with a response pending
        cmd_opcode = OP_LOAD_WEIGHT;
        cmd_addra  = 8'h01;
        cmd_addrb  = 8'h02;
        cmd_valid  = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        repeat (8) @(negedge clk);
        #1;
        chk("lw_inst_mid", instruction, 20'h40102);
        chk("lw_rsp_pending", rsp_valid, 1);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_inst", instruction, 0);
        chk("arst_rsp_valid", rsp_valid, 0);
        chk("arst_busy", busy, 0);
        chk("arst_rsp_data", rsp_data, 0);
        @(negedge clk);
        reset_n = 1'b1;

        // Randomized traffic against the model, from a fresh reset
        do_reset();
        m_rem = 0; m_read = 0; m_inst = '0; m_din = '0; m_rv = 0; m_rd = '0; m_err = 0;
        for (int c = 0; c < 3000; c++) begin
            cmd_valid  = ($urandom_range(0, 3) == 0);
            cmd_opcode = 4'($urandom_range(0, 15));
            cmd_addra  = 8'($urandom);
            cmd_addrb  = 8'($urandom);
            cmd_din    = {$urandom, $urandom, $urandom, $urandom};
            rsp_ready  = ($urandom_range(0, 2) == 0);
            dout       = rnd320();
            #1;
            exp_ready = (m_rem == 0) && !((cmd_opcode == 4'd8) && m_rv && !rsp_ready);
            chk("rnd_ready", cmd_ready, exp_ready);
            chk("rnd_inst", instruction, m_inst);
            chk("rnd_din", din, m_din);
            chk("rnd_busy", busy, m_rem > 0);
            chk("rnd_err", err_opcode, m_err);
            chk("rnd_rsp_valid", rsp_valid, m_rv);
            if (m_rv) chk("rnd_rsp_data", rsp_data, m_rd);
            @(posedge clk);
            if (m_rem == 1 && m_read) begin
                m_rv = 1'b1;
                m_rd = dout;
            end else if (m_rv && rsp_ready) begin
                m_rv = 1'b0;
            end
            m_err = 1'b0;
            if (m_rem > 0) begin
                m_rem--;
                if (m_rem == 0) begin
                    m_inst = '0;
                    m_read = 1'b0;
                end
            end else if (cmd_valid && exp_ready) begin
                legal  = (cmd_opcode <= 4'd8);
                m_rem  = hold_tab[cmd_opcode];
                m_read = (cmd_opcode == 4'd8);
                m_err  = !legal;
                m_inst = legal ? {cmd_opcode, cmd_addra, cmd_addrb} : 20'h0;
                if (legal) m_din = cmd_din;
            end
            @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
